wallace_mult_arbiter: RTL and testbench

//   Shares one 8-PP x 16-bit carry-save tree (wallace_tree_new) between two requesters doing signed 8x8 multiplies.

---
 rtl/wallace_mult_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_wallace_mult_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_mult_arbiter.sv
// wallace_mult_arbiter
//   Two requesters share one signed 8x8 multiplier. A round-robin arbiter grants
//   at most one request per cycle. The operands then go through a 3-stage
//   valid/ready pipeline:
//     S1  captures the granted operands and the requester id
//     S2  builds 8 partial products and reduces them with a carry-save tree
//     S3  does the final carry-propagate add
//   A stalled output (out_valid_o && !out_ready_i) freezes every stage.
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid_i/reqN_ready_o   request handshake for requester N (N = 0, 1)
//   reqN_a_i, reqN_b_i          signed multiplicand and multiplier
//   out_valid_o/out_ready_i     product handshake
//   out_product_o, out_id_o     signed product and the requester that issued it
//   op_count_o                  count of delivered products, wraps

module wallace_mult_arbiter #(
  parameter int unsigned OpW  = 8,
  parameter int unsigned PW   = 16,
  parameter int unsigned CntW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [OpW-1:0]  req0_a_i,
  input  logic [OpW-1:0]  req0_b_i,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [OpW-1:0]  req1_a_i,
  input  logic [OpW-1:0]  req1_b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [PW-1:0]   out_product_o,
  output logic            out_id_o,
  output logic [CntW-1:0] op_count_o
);

  // 3:2 compressor over whole words; the carry word is pre-shifted.
  function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                            input logic [PW-1:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                              input logic [PW-1:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic            stall;
  logic            grant0, grant1;
  logic            rr_q, rr_d;

  logic            s1_valid_q, s1_valid_d;
  logic [OpW-1:0]  s1_a_q, s1_a_d;
  logic [OpW-1:0]  s1_b_q, s1_b_d;
  logic            s1_id_q, s1_id_d;

  logic            s2_valid_q, s2_valid_d;
  logic [PW-1:0]   s2_sum_q, s2_sum_d;
  logic [PW-1:0]   s2_carry_q, s2_carry_d;
  logic            s2_cin_q, s2_cin_d;
  logic            s2_id_q, s2_id_d;

  logic            out_valid_q, out_valid_d;
  logic [PW-1:0]   out_product_q, out_product_d;
  logic            out_id_q, out_id_d;
  logic [CntW-1:0] op_count_q, op_count_d;

  logic [PW-1:0]   as;
  logic [PW-1:0]   pp [OpW];
  logic [PW-1:0]   s10, c10, s11, c11, s20, c20, s21, c21, s30, c30;

  assign stall = out_valid_q & ~out_ready_i;

  // rr_q names the requester that wins when both are valid.
  assign grant0 = ~stall & req0_valid_i & (~req1_valid_i | ~rr_q);
  assign grant1 = ~stall & req1_valid_i & (~req0_valid_i | rr_q);

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  always_comb begin
    rr_d = rr_q;
    if (grant0) begin
      rr_d = 1'b1;
    end else if (grant1) begin
      rr_d = 1'b0;
    end
  end

  // Stage 1: operand capture.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    if (!stall) begin
      s1_valid_d = grant0 | grant1;
      if (grant0) begin
        s1_a_d  = req0_a_i;
        s1_b_d  = req0_b_i;
        s1_id_d = 1'b0;
      end else if (grant1) begin
        s1_a_d  = req1_a_i;
        s1_b_d  = req1_b_i;
        s1_id_d = 1'b1;
      end
    end
  end

  // Stage 2: partial products. The sign row is inverted here; its +1 travels
  // as cin into the final add.
  always_comb begin
    as = {{(PW - OpW){s1_a_q[OpW-1]}}, s1_a_q};
    for (int i = 0; i < OpW - 1; i++) begin
      pp[i] = s1_b_q[i] ? (as << i) : '0;
    end
    pp[OpW-1] = s1_b_q[OpW-1] ? ~(as << (OpW - 1)) : '0;
  end

  // Carry-save tree: 8 rows -> 6 -> 4 -> 3 -> 2.
  always_comb begin
    s10 = csa_sum(pp[0], pp[1], pp[2]);
    c10 = csa_carry(pp[0], pp[1], pp[2]);
    s11 = csa_sum(pp[3], pp[4], pp[5]);
    c11 = csa_carry(pp[3], pp[4], pp[5]);
    s20 = csa_sum(s10, c10, s11);
    c20 = csa_carry(s10, c10, s11);
    s21 = csa_sum(c11, pp[6], pp[7]);
    c21 = csa_carry(c11, pp[6], pp[7]);
    s30 = csa_sum(s20, c20, s21);
    c30 = csa_carry(s20, c20, s21);
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_carry_d = s2_carry_q;
    s2_cin_d   = s2_cin_q;
    s2_id_d    = s2_id_q;
    if (!stall) begin
      s2_valid_d = s1_valid_q;
      s2_sum_d   = csa_sum(s30, c30, c21);
      s2_carry_d = csa_carry(s30, c30, c21);
      s2_cin_d   = s1_b_q[OpW-1];
      s2_id_d    = s1_id_q;
    end
  end

  // Stage 3: carry-propagate add.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;
    out_id_d      = out_id_q;
    if (!stall) begin
      out_valid_d   = s2_valid_q;
      out_product_d = s2_sum_q + s2_carry_q + PW'(s2_cin_q);
      out_id_d      = s2_id_q;
    end
  end

  always_comb begin
    op_count_d = op_count_q;
    if (out_valid_q && out_ready_i) begin
      op_count_d = op_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q          <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      s1_id_q       <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_sum_q      <= '0;
      s2_carry_q    <= '0;
      s2_cin_q      <= 1'b0;
      s2_id_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      out_id_q      <= 1'b0;
      op_count_q    <= '0;
    end else begin
      rr_q          <= rr_d;
      s1_valid_q    <= s1_valid_d;
      s1_a_q        <= s1_a_d;
      s1_b_q        <= s1_b_d;
      s1_id_q       <= s1_id_d;
      s2_valid_q    <= s2_valid_d;
      s2_sum_q      <= s2_sum_d;
      s2_carry_q    <= s2_carry_d;
      s2_cin_q      <= s2_cin_d;
      s2_id_q       <= s2_id_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
      out_id_q      <= out_id_d;
      op_count_q    <= op_count_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_product_o = out_product_q;
  assign out_id_o      = out_id_q;
  assign op_count_o    = op_count_q;

endmodule

// File: tb/tb_wallace_mult_arbiter.sv
// Self-checking bench for wallace_mult_arbiter. A negedge monitor predicts the
// grants from the arbitration rules, keeps the expected products in a FIFO
// (a*b computed with integer arithmetic) and checks every delivered product,
// the stall-hold behaviour and the delivered-product count.

module tb_wallace_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1, r0, r1, ov, ordy, oid;
  logic [7:0]  a0, b0, a1, b1;
  logic [15:0] prod, cnt;

  int          n_chk  = 0;
  int          n_fail = 0;

  // Reference model state.
  logic [16:0] expq [$];
  bit          rr_m;
  logic [15:0] cnt_m;
  int          n_grants;
  bit          mon_en = 1'b0;
  bit          prev_stall;
  logic [15:0] prev_prod;
  logic        prev_id;

  always #5 clk = ~clk;

  wallace_mult_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid_i (v0),
    .req0_ready_o (r0),
    .req0_a_i     (a0),
    .req0_b_i     (b0),
    .req1_valid_i (v1),
    .req1_ready_o (r1),
    .req1_a_i     (a1),
    .req1_b_i     (b1),
    .out_valid_o  (ov),
    .out_ready_i  (ordy),
    .out_product_o(prod),
    .out_id_o     (oid),
    .op_count_o   (cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  function automatic logic [7:0] rand_op();
    logic [7:0] v;
    case ($urandom_range(0, 7))
      0:       v = 8'h80;
      1:       v = 8'h7f;
      2:       v = 8'hff;
      3:       v = 8'h00;
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  always @(negedge clk) begin : mon
    logic [16:0] e;
    bit          stall, g0, g1;
    if (rst_n && mon_en) begin
      stall = ov && !ordy;
      g0    = !stall && v0 && (!v1 || !rr_m);
      g1    = !stall && v1 && (!v0 || rr_m);
      check("req0_ready", r0, g0);
      check("req1_ready", r1, g1);
      check("op_count", cnt, cnt_m);
      if (prev_stall) begin
        check("hold_valid", ov, 1'b1);
        check("hold_product", prod, prev_prod);
        check("hold_id", oid, prev_id);
      end
      if (ov && ordy) begin
        if (expq.size() == 0) begin
          check("spurious_out", ov, 1'b0);
        end else begin
          e = expq.pop_front();
          check("product", prod, e[15:0]);
          check("out_id", oid, e[16]);
        end
        cnt_m++;
      end
      if (g0) begin
        expq.push_back({1'b0, ref_mul(a0, b0)});
        rr_m = 1'b1;
        n_grants++;
      end else if (g1) begin
        expq.push_back({1'b1, ref_mul(a1, b1)});
        rr_m = 1'b0;
        n_grants++;
      end
      prev_stall = stall;
      prev_prod  = prod;
      prev_id    = oid;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    expq.delete();
    rr_m       = 1'b0;
    cnt_m      = '0;
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v0    = 1'b0;
    v1    = 1'b0;
    ordy  = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ca [5];
    logic [7:0] cb [5];
    int         w;
    int         cycles;
    logic [15:0] held;

    v0 = 0; v1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; ordy = 1; rst_n = 0;
    mon_en = 1'b1;
    do_reset();

    // Reset state
    check("rst_valid", ov, 1'b0);
    check("rst_product", prod, 16'h0);
    check("rst_id", oid, 1'b0);
    check("rst_count", cnt, 16'h0);
    check("rst_ready0", r0, 1'b0);
    check("rst_ready1", r1, 1'b0);

    // Single op, 3-cycle latency
    v0 = 1; a0 = 8'd3; b0 = 8'd5;
    @(negedge clk);
    check("single_ready", r0, 1'b1);
    cyc();
    v0 = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("single_latency", ov, (k == 3));
    end
    check("single_product", prod, 16'd15);
    check("single_id", oid, 1'b0);
    cyc();

    // Signed corners, back to back on both ports
    ca[0] = 8'h80; cb[0] = 8'h80;
    ca[1] = 8'h80; cb[1] = 8'h7f;
    ca[2] = 8'h7f; cb[2] = 8'h7f;
    ca[3] = 8'hff; cb[3] = 8'h01;
    ca[4] = 8'h00; cb[4] = 8'h80;
    for (int i = 0; i < 5; i++) begin
      v0 = 1; a0 = ca[i]; b0 = cb[i];
      cyc();
    end
    v0 = 0;
    for (int i = 0; i < 5; i++) begin
      v1 = 1; a1 = ca[i]; b1 = cb[i];
      cyc();
    end
    v1 = 0;
    repeat (5) cyc();

    // Contention from reset: strict alternation starting with requester 0
    do_reset();
    v0 = 1; v1 = 1;
    for (int i = 0; i < 6; i++) begin
      a0 = rand_op(); b0 = rand_op(); a1 = rand_op(); b1 = rand_op();
      @(negedge clk);
      check("cont_grant0", r0, (i % 2 == 0));
      check("cont_grant1", r1, (i % 2 == 1));
      cyc();
    end
    v0 = 0; v1 = 0;
    repeat (6) cyc();

    // Backpressure: 4 ops, then out_ready low for 5 cycles with a request pending
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v0 = 1; a0 = rand_op(); b0 = rand_op();
      @(negedge clk);
      check("bp_issue", r0, 1'b1);
      cyc();
    end
    ordy = 0; a0 = 8'd7; b0 = 8'd9;
    @(negedge clk);
    held = prod;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_noready", r0, 1'b0);
      check("bp_stable", prod, held);
      cyc();
    end
    v0 = 0; ordy = 1;
    w = 0;
    while (cnt != 16'd4 && w < 20) begin
      cyc();
      w++;
    end
    check("bp_count", cnt, 16'd4);
    repeat (2) cyc();
    check("bp_count_final", cnt, 16'd4);

    // Async reset with ops in flight
    do_reset();
    for (int i = 0; i < 3; i++) begin
      v0 = 1; a0 = rand_op(); b0 = rand_op();
      cyc();
    end
    v0 = 0;
    #2 rst_n = 0;
    #1;
    check("arst_valid", ov, 1'b0);
    check("arst_count", cnt, 16'h0);
    check("arst_product", prod, 16'h0);
    clear_model();
    @(posedge clk);
    #1 rst_n = 1;
    v0 = 1; v1 = 1; a0 = 8'd2; b0 = 8'd2; a1 = 8'd3; b1 = 8'd3;
    @(negedge clk);
    check("arst_rr", r0, 1'b1);
    cyc();
    v0 = 0; v1 = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("arst_nostale", ov, 1'b0);
      cyc();
    end
    repeat (4) cyc();

    // Random traffic
    do_reset();
    n_grants = 0;
    cycles   = 0;
    while (n_grants < 10000 && cycles < 60000) begin
      v0   = 1'($urandom_range(0, 1));
      v1   = 1'($urandom_range(0, 1));
      a0   = rand_op(); b0 = rand_op();
      a1   = rand_op(); b1 = rand_op();
      ordy = ($urandom_range(0, 3) != 0);
      cyc();
      cycles++;
    end
    check("rand_budget", (n_grants >= 10000), 1'b1);
    v0 = 0; v1 = 0; ordy = 1;
    repeat (8) cyc();
    check("drain_empty", expq.size(), 0);
    check("drain_count", cnt, cnt_m);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
